seq_mult: RTL and testbench
===========================

SEQ_MULT -- requirements
Module: seq_mult

Interface
REQ-001 Parameter N, default 32: operand width in bits; product width is 2N.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; low clears all state immediately, independent of clk.
REQ-004 multiplicand  input  N  signed two's-complement operand M.
REQ-005 multiplier  input  N  signed two's-complement operand Q.
REQ-006 product  output  2N  signed two's-complement result M*Q, registered.
REQ-007 done  output  1  high when product holds the final result of the current operation.

Function
REQ-008 The block SHALL implement radix-2 Booth sequential multiplication: accumulator A (N+1 bits, sign-extended), register Q (N bits), bit Q_1, register Mreg (N+1 bits, sign-extended M), iteration counter (ceil(log2(N+1)) bits).
REQ-009 The block SHALL use three states: LOAD, RUN, DONE.
REQ-010 In LOAD (first rising clk edge after reset goes high), the block SHALL capture multiplicand into Mreg and multiplier into Q, clear A, Q_1 and counter, and go to RUN.
REQ-011 In each RUN cycle, based on {Q[0],Q_1}: 01 -> A = A + Mreg; 10 -> A = A - Mreg; 00/11 -> A unchanged; then arithmetic right shift of {A,Q,Q_1} by one bit (A MSB replicated), counter incremented.
REQ-012 After exactly N RUN cycles the block SHALL go to DONE, load product with {A[N-1:0],Q}, and assert done.
REQ-013 Latency: product valid and done high on the (N+2)th rising clk edge after reset deassertion (N=32: edge 34).
REQ-014 In DONE, product and done SHALL hold unchanged until the next reset assertion; the block SHALL NOT start a new operation without reset.
REQ-015 Operand changes after the LOAD edge SHALL be ignored for the current operation.
REQ-016 Before DONE, product SHALL read 0 and done SHALL be 0.
REQ-017 Full-range correctness: result SHALL equal exact signed product for all operand pairs, including M = -2^(N-1) and Q = -2^(N-1) (product 2^(2N-2)); the N+1-bit A prevents overflow.
REQ-018 Zero operands SHALL yield product 0 with the same latency (no early termination).

Reset
REQ-019 While reset is low: state = LOAD, A, Q, Q_1, Mreg, counter = 0, product = 0, done = 0, asynchronously.
REQ-020 Reset asserted mid-RUN or in DONE SHALL abort the operation and clear all outputs immediately; a new operation starts on the first edge after release, using operands present at that edge.
REQ-021 Reset deassertion SHALL be treated as synchronous to clk for the LOAD transition (no partial-cycle iteration).

Verification
REQ-022 M=7, Q=2, reset pulse low then high, wait 34 edges -> product=14, done=1.
REQ-023 Sign mix: (-7,3) -> -21; (20,-10) -> -200; (-19,3) -> -57; (2,-125) -> -250; (-2,-2) -> 4; each after a fresh reset pulse.
REQ-024 Zeros: (0,-60), (-80,0), (0,3), (5,0) -> product=0 with done at edge 34, not earlier.
REQ-025 Extremes: (-2^31,-2^31) -> 2^62; (-2^31,1) -> -2^31 sign-extended to 64 bits; (2^31-1,2^31-1) -> 2^62-2^32+1.
REQ-026 Abort: start (7,2), assert reset at edge 10 -> product=0, done=0 immediately; release with (-7,3) -> -21 at edge 34 after release.
REQ-027 Hold: after done, change operands for 50 cycles -> product and done unchanged.

Source files
------------

// File: rtl/seq_mult.sv
// seq_mult: radix-2 Booth sequential signed multiplier, one operation per reset release.
module seq_mult #(
  parameter int N = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     multiplicand,
  input  logic [N-1:0]     multiplier,
  output logic [2*N-1:0]   product,
  output logic             done
);
  localparam int CW = $clog2(N + 1);
  typedef enum logic [1:0] {LOAD, RUN, DONE} state_t;
  state_t         state_q, state_d;
  logic [N:0]     a_q, a_d, m_q, m_d, a_sel;
  logic [N-1:0]   q_q, q_d;
  logic           q1_q, q1_d, done_q, done_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*N-1:0] product_q, product_d;
  assign a_sel = ({q_q[0], q1_q} == 2'b01) ? a_q + m_q :
                 ({q_q[0], q1_q} == 2'b10) ? a_q - m_q : a_q;
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    m_d       = m_q;
    q_d       = q_q;
    q1_d      = q1_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    done_d    = done_q;
    case (state_q)
      LOAD: begin
        m_d     = {multiplicand[N-1], multiplicand};
        q_d     = multiplier;
        a_d     = '0;
        q1_d    = 1'b0;
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        // one extra RUN cycle after the Nth iteration registers the result
        if (cnt_q == CW'(N)) begin
          state_d   = DONE;
          product_d = {a_q[N-1:0], q_q};
          done_d    = 1'b1;
        end else begin
          {a_d, q_d, q1_d} = {a_sel[N], a_sel, q_q};
          cnt_d            = cnt_q + 1'b1;
        end
      end
      default: state_d = DONE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= LOAD;
      a_q       <= '0;
      m_q       <= '0;
      q_q       <= '0;
      q1_q      <= 1'b0;
      cnt_q     <= '0;
      product_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      m_q       <= m_d;
      q_q       <= q_d;
      q1_q      <= q1_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      done_q    <= done_d;
    end
  end
  assign product = product_q;
  assign done    = done_q;
endmodule

// File: tb/tb_seq_mult.sv
// tb_seq_mult: directed Booth multiplier vectors with hand-computed products and latency checks.
module tb_seq_mult;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] multiplicand = '0;
  logic [31:0] multiplier = '0;
  logic [63:0] product;
  logic        done;
  int          checks = 0;
  int          errors = 0;
  seq_mult #(.N(32)) dut (
    .clk(clk),
    .reset(reset),
    .multiplicand(multiplicand),
    .multiplier(multiplier),
    .product(product),
    .done(done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  // edges counted from reset release; operands scrambled after the LOAD edge
  task automatic wait_done(input string tag, input logic [63:0] exp);
    for (int k = 1; k <= 34; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) begin
        multiplicand = ~multiplicand;
        multiplier   = multiplier ^ 32'h5A5A_5A5A;
      end
      if (k == 33) begin
        chk({tag, "_early_done"}, {63'd0, done}, 64'd0);
        chk({tag, "_early_prod"}, product, 64'd0);
      end
      if (k == 34) begin
        chk({tag, "_done"}, {63'd0, done}, 64'd1);
        chk({tag, "_prod"}, product, exp);
      end
    end
  endtask
  task automatic run_op(input string tag, input logic [31:0] m, input logic [31:0] q,
                        input logic [63:0] exp);
    @(negedge clk);
    reset = 1'b0;
    multiplicand = m;
    multiplier   = q;
    #1;
    chk({tag, "_rst_prod"}, product, 64'd0);
    chk({tag, "_rst_done"}, {63'd0, done}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    wait_done(tag, exp);
  endtask
  initial begin
    #2;
    chk("reset_prod", product, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);
    run_op("m7q2", 32'd7, 32'd2, 64'd14);
    run_op("n7q3", -32'sd7, 32'd3, -64'sd21);
    run_op("m20n10", 32'd20, -32'sd10, -64'sd200);
    run_op("n19q3", -32'sd19, 32'd3, -64'sd57);
    run_op("m2n125", 32'd2, -32'sd125, -64'sd250);
    run_op("n2n2", -32'sd2, -32'sd2, 64'd4);
    run_op("z_0n60", 32'd0, -32'sd60, 64'd0);
    run_op("z_n80_0", -32'sd80, 32'd0, 64'd0);
    run_op("z_0_3", 32'd0, 32'd3, 64'd0);
    run_op("z_5_0", 32'd5, 32'd0, 64'd0);
    run_op("minmin", 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    run_op("min_1", 32'h8000_0000, 32'd1, 64'hFFFF_FFFF_8000_0000);
    run_op("maxmax", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001);
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      multiplicand = 32'h1234_0000 + 32'(c);
      multiplier   = 32'hFFFF_0000 - 32'(c);
      @(posedge clk);
      #1;
      chk("hold_prod", product, 64'h3FFF_FFFF_0000_0001);
      chk("hold_done", {63'd0, done}, 64'd1);
    end
    #3;
    reset = 1'b0;
    #1;
    chk("clr_done_prod", product, 64'd0);
    chk("clr_done_done", {63'd0, done}, 64'd0);
    @(negedge clk);
    multiplicand = 32'd7;
    multiplier   = 32'd2;
    @(negedge clk);
    reset = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("abort_prod", product, 64'd0);
    chk("abort_done", {63'd0, done}, 64'd0);
    multiplicand = -32'sd7;
    multiplier   = 32'd3;
    @(negedge clk);
    reset = 1'b1;
    wait_done("abort_new", -64'sd21);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
